mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single memory port between the instruction-fetch and data
//   requesters of a pipelined core. Data normally wins a contested grant.
//   After STARVE_MAX consecutive data grants made while fetch was waiting,
//   fetch wins the next contested grant. A BUSY state that sees no
//   mem_ready for TIMEOUT cycles pulses err and returns to IDLE. The
//   requester stays stalled and is arbitrated again from IDLE.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   if_req/if_addr        fetch request (held until if_valid) and address
//   if_rdata/if_valid     fetch read data and completion
//   d_req/d_we/d_addr/
//   d_wdata               data request (held until d_valid) and payload
//   d_rdata/d_valid       data read value and completion (read or write)
//   mem_req/mem_we/
//   mem_addr/mem_wdata    shared port request, driven from latched payload
//   mem_rdata/mem_ready   shared port return data and completion
//   StallF/StallD/StallM  pipeline stalls
//   err                   one-cycle pulse on wait timeout
//
// state   | meaning
// IDLE    | no access in flight; arbitrate pending requests
// IF_BUSY | fetch access on the memory port, waiting for mem_ready
// D_BUSY  | data access on the memory port, waiting for mem_ready
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        StallF,
  output logic        StallD,
  output logic        StallM,
  output logic        err
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WAIT_LIM   = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic busy;
  logic timeout;
  logic arb_pt;
  logic if_cand;
  logic d_cand;
  logic grant_if;
  logic grant_d;

  assign busy     = (state_q != IDLE);
  assign if_valid = (state_q == IF_BUSY) && mem_ready;
  assign d_valid  = (state_q == D_BUSY) && mem_ready;
  assign timeout  = busy && !mem_ready && (wait_q == WAIT_LIM);
  assign err      = timeout;

  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

  assign mem_req   = busy;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign StallF = if_req && !if_valid;
  assign StallD = StallF;
  assign StallM = d_req && !d_valid;

  // A requester's req is still high in its own completion cycle; masking it
  // with its valid keeps the just-finished request from being granted again.
  assign arb_pt   = (state_q == IDLE) || if_valid || d_valid;
  assign if_cand  = if_req && !if_valid;
  assign d_cand   = d_req && !d_valid;
  assign grant_if = arb_pt && if_cand && (!d_cand || (starve_q == STARVE_LIM));
  assign grant_d  = arb_pt && d_cand && !grant_if;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wait_d   = wait_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if (grant_if) begin
      state_d  = IF_BUSY;
      addr_d   = if_addr;
      we_d     = 1'b0;
      wdata_d  = '0;
      wait_d   = '0;
      starve_d = '0;
    end else if (grant_d) begin
      state_d = D_BUSY;
      addr_d  = d_addr;
      we_d    = d_we;
      wdata_d = d_wdata;
      wait_d  = '0;
      // only count data grants that actually made a waiting fetch wait longer
      if (if_cand && (starve_q != STARVE_LIM)) begin
        starve_d = starve_q + SW'(1);
      end
    end else if (arb_pt || timeout) begin
      state_d = IDLE;
    end else if (busy) begin
      wait_d = wait_q + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      wait_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        StallF;
  logic        StallD;
  logic        StallM;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .StallF(StallF), .StallD(StallD), .StallM(StallM), .err(err)
  );

  // inputs change 1 ns after the rising edge; outputs are sampled 4 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    mem_ready = 1'b1;
    #3;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b exp 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b exp 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    checks++; if ({err, if_valid, d_valid} !== 3'b000) begin errors++; $display("FAIL reset_err_valid got %b exp 000", {err, if_valid, d_valid}); end
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h44;
    #4;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_hold_mem_req got %0b exp 0", mem_req); end
    checks++; if (StallF !== 1'b1) begin errors++; $display("FAIL reset_stallf got %0b exp 1", StallF); end
    tick();
    reset = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_fetch_only();
    if_req = 1'b1; if_addr = 32'h0000_0010; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    #4;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_c0_mem_req got %0b exp 0", mem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fetch_c0_ready_ignored got %0b exp 0", if_valid); end
    checks++; if (StallF !== 1'b1) begin errors++; $display("FAIL fetch_c0_stallf got %0b exp 1", StallF); end
    tick();
    mem_rdata = 32'hCAFE_0001;
    #4;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_c1_mem_req got %0b exp 1", mem_req); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL fetch_c1_addr got %h exp 10", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch_c1_we got %0b exp 0", mem_we); end
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL fetch_c1_valid got %0b exp 1", if_valid); end
    checks++; if (if_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL fetch_c1_rdata got %h exp cafe0001", if_rdata); end
    checks++; if ({StallF, StallD} !== 2'b00) begin errors++; $display("FAIL fetch_c1_stall got %b exp 00", {StallF, StallD}); end
    tick();
    if_req = 1'b0; mem_ready = 1'b0;
    #4;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_c2_mem_req got %0b exp 0", mem_req); end
    tick();
  endtask

  task automatic test_data_write();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; mem_ready = 1'b0;
    #4;
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL dw_c0_stallm got %0b exp 1", StallM); end
    for (int i = 0; i < 4; i++) begin
      tick();
      d_addr = $urandom();
      d_wdata = $urandom();
      mem_ready = (i == 3);
      #4;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL dw_mem_req i=%0d got %0b exp 1", i, mem_req); end
      checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h100, 32'hDEAD_BEEF}) begin
        errors++; $display("FAIL dw_payload i=%0d got %0b/%h/%h exp 1/100/deadbeef", i, mem_we, mem_addr, mem_wdata);
      end
      checks++; if (d_valid !== (i == 3)) begin errors++; $display("FAIL dw_valid i=%0d got %0b exp %0b", i, d_valid, i == 3); end
      checks++; if (StallM !== (i != 3)) begin errors++; $display("FAIL dw_stallm i=%0d got %0b exp %0b", i, StallM, i != 3); end
    end
    tick();
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b1;
    #4;
    checks++; if ({mem_req, d_valid, if_valid} !== 3'b000) begin errors++; $display("FAIL dw_after got %b exp 000", {mem_req, d_valid, if_valid}); end
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_ready = 1'b0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      tick();
      #4;
      checks++; if ({mem_req, d_valid, StallM} !== 3'b101) begin errors++; $display("FAIL to_busy c=%0d got %b exp 101", c, {mem_req, d_valid, StallM}); end
      checks++; if (err !== (c == TIMEOUT)) begin errors++; $display("FAIL to_err c=%0d got %0b exp %0b", c, err, c == TIMEOUT); end
    end
    tick();
    #4;
    checks++; if ({mem_req, err, StallM} !== 3'b001) begin errors++; $display("FAIL to_idle got %b exp 001", {mem_req, err, StallM}); end
    tick();
    mem_ready = 1'b1;
    #4;
    checks++; if ({mem_req, d_valid} !== 2'b11 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL to_regrant got %b addr %h exp 11 addr 200", {mem_req, d_valid}, mem_addr);
    end
    tick();
    d_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_alternation();
    int n = 0;
    logic prev_req = 1'b0, prev_valid = 1'b0, f_done, d_done, is_d;
    if_req = 1'b1; if_addr = 32'h1000_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000_0000; mem_ready = 1'b1;
    for (int c = 0; c < 40 && n < 10; c++) begin
      #4;
      if (mem_req && (!prev_req || prev_valid)) begin
        is_d = (mem_addr[31:28] == 4'h2);
        checks++; if (is_d !== (n % 2 == 0)) begin errors++; $display("FAIL alt_grant n=%0d got data=%0b exp data=%0b", n, is_d, n % 2 == 0); end
        if (is_d) begin
          checks++; if (StallF !== 1'b1) begin errors++; $display("FAIL alt_stallf n=%0d got %0b exp 1", n, StallF); end
        end
        n++;
      end
      prev_req = mem_req; prev_valid = if_valid | d_valid;
      f_done = if_valid; d_done = d_valid;
      tick();
      if (f_done) if_addr = if_addr + 32'd4;
      if (d_done) d_addr = d_addr + 32'd4;
    end
    checks++; if (n != 10) begin errors++; $display("FAIL alt_count got %0d exp 10", n); end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    mem_ready = 1'b0;
    tick();
  endtask

  // Repeated data timeouts keep fetch waiting: after STARVE_MAX data grants the
  // contested grant goes to fetch, then data follows back-to-back.
  task automatic test_starvation();
    int n = 0, errs = 0, dvals = 0;
    int gcyc[6];
    logic prev_req = 1'b0, prev_valid = 1'b0, f_done, d_done, is_d, go_ready = 1'b0;
    if_req = 1'b1; if_addr = 32'h1000_0100;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000_0100; d_wdata = 32'h5A5A_0001; mem_ready = 1'b0;
    for (int c = 0; c < 200 && (if_req || d_req); c++) begin
      #4;
      if (mem_req && (!prev_req || prev_valid)) begin
        is_d = (mem_addr[31:28] == 4'h2);
        checks++; if (is_d !== (n != 4)) begin errors++; $display("FAIL starve_grant n=%0d got data=%0b exp data=%0b", n, is_d, n != 4); end
        if (n < 6) gcyc[n] = c;
        if (!is_d) go_ready = 1'b1;
        n++;
      end
      if (err) errs++;
      if (d_valid) dvals++;
      prev_req = mem_req; prev_valid = if_valid | d_valid;
      f_done = if_valid; d_done = d_valid;
      tick();
      if (go_ready) mem_ready = 1'b1;
      if (f_done) if_req = 1'b0;
      if (d_done) d_req = 1'b0;
    end
    checks++; if (n != 6) begin errors++; $display("FAIL starve_count got %0d exp 6", n); end
    checks++; if (errs != 4) begin errors++; $display("FAIL starve_errs got %0d exp 4", errs); end
    checks++; if (dvals != 1) begin errors++; $display("FAIL starve_dvalids got %0d exp 1", dvals); end
    if (n == 6) begin
      checks++; if (gcyc[1] - gcyc[0] != TIMEOUT + 1) begin errors++; $display("FAIL starve_gap01 got %0d exp %0d", gcyc[1] - gcyc[0], TIMEOUT + 1); end
      checks++; if (gcyc[4] - gcyc[3] != TIMEOUT + 1) begin errors++; $display("FAIL starve_gap34 got %0d exp %0d", gcyc[4] - gcyc[3], TIMEOUT + 1); end
      checks++; if (gcyc[5] - gcyc[4] != 2) begin errors++; $display("FAIL starve_gap45 got %0d exp 2", gcyc[5] - gcyc[4]); end
    end
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h0000_0ABC; mem_ready = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_busy got %0b exp 1", mem_req); end
    reset = 1'b0; mem_ready = 1'b1;
    #1;
    checks++; if ({mem_req, if_valid, err} !== 3'b000) begin errors++; $display("FAIL rm_async got %b exp 000", {mem_req, if_valid, err}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rm_addr got %h exp 0", mem_addr); end
    tick();
    reset = 1'b1; mem_ready = 1'b0;
    #4;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_release got %0b exp 0", mem_req); end
    tick();
    mem_ready = 1'b1;
    #4;
    checks++; if ({mem_req, if_valid} !== 2'b11 || mem_addr !== 32'hABC) begin
      errors++; $display("FAIL rm_regrant got %b addr %h exp 11 addr abc", {mem_req, if_valid}, mem_addr);
    end
    tick();
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  // Reference model: owner of the port (0 none, 1 fetch, 2 data), latched
  // payload, cycles waited, and data grants issued since fetch was last served.
  task automatic test_random();
    int owner = 0, waited = 0, starve = 0, burst = 0;
    logic [31:0] l_addr = '0, l_wdata = '0;
    logic l_we = 1'b0, f_done = 1'b0, d_done = 1'b0, e_ifv, e_dv, e_err, f_pend, d_pend;
    reset = 1'b0; idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    for (int c = 0; c < 800; c++) begin
      if (f_done) if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = $urandom(); end
      if (d_done) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom(); d_wdata = $urandom();
      end
      if (burst > 0) burst--;
      else if ($urandom_range(0, 39) == 0) burst = 20;
      mem_ready = (burst == 0) && ($urandom_range(0, 9) < 6);
      mem_rdata = $urandom();
      #4;
      e_ifv = (owner == 1) && mem_ready;
      e_dv  = (owner == 2) && mem_ready;
      e_err = (owner != 0) && !mem_ready && (waited == TIMEOUT - 1);
      checks++; if (mem_req !== (owner != 0)) begin errors++; $display("FAIL rnd_mem_req c=%0d got %0b exp %0b", c, mem_req, owner != 0); end
      checks++; if ({mem_we, mem_addr, mem_wdata} !== {l_we, l_addr, l_wdata}) begin
        errors++; $display("FAIL rnd_payload c=%0d got %0b/%h/%h exp %0b/%h/%h", c, mem_we, mem_addr, mem_wdata, l_we, l_addr, l_wdata);
      end
      checks++; if ({if_valid, d_valid} !== {e_ifv, e_dv}) begin errors++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, {if_valid, d_valid}, {e_ifv, e_dv}); end
      checks++; if (err !== e_err) begin errors++; $display("FAIL rnd_err c=%0d got %0b exp %0b", c, err, e_err); end
      checks++; if ({StallF, StallD, StallM} !== {if_req && !e_ifv, if_req && !e_ifv, d_req && !e_dv}) begin
        errors++; $display("FAIL rnd_stall c=%0d got %b exp %b", c, {StallF, StallD, StallM}, {if_req && !e_ifv, if_req && !e_ifv, d_req && !e_dv});
      end
      checks++; if (d_rdata !== mem_rdata || if_rdata !== mem_rdata) begin errors++; $display("FAIL rnd_rdata c=%0d got %h/%h exp %h", c, if_rdata, d_rdata, mem_rdata); end
      f_done = e_ifv; d_done = e_dv;
      if (owner != 0 && !mem_ready) begin
        if (waited == TIMEOUT - 1) owner = 0;
        else waited++;
      end else begin
        f_pend = if_req && !e_ifv;
        d_pend = d_req && !e_dv;
        if (f_pend && (!d_pend || starve == STARVE_MAX)) begin
          owner = 1; l_addr = if_addr; l_we = 1'b0; l_wdata = '0; waited = 0; starve = 0;
        end else if (d_pend) begin
          owner = 2; l_addr = d_addr; l_we = d_we; l_wdata = d_wdata; waited = 0;
          if (f_pend && starve < STARVE_MAX) starve++;
        end else begin
          owner = 0;
        end
      end
      tick();
    end
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_data_write();
    test_timeout();
    test_alternation();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "simulation did not complete");
  end

endmodule
